// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the memory-stage load/store unit.
//   - funct3 encodings for the RV32I load/store access sizes
//   - access FSM state type
//   - helper functions that place store data and byte strobes on the
//     word-aligned data bus
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    // Byte-lane enables for a store of the given size at byte offset 'offset'.
    // Only legal, aligned stores reach this, so halfwords use offset[1] alone.
    function automatic logic [3:0] store_strobe(input logic [2:0] funct3,
                                                input logic [1:0] offset);
        logic [3:0] strobe;
        strobe = 4'b0000;
        case (funct3)
            F3_B:    strobe = 4'b0001 << offset;
            F3_H:    strobe = offset[1] ? 4'b1100 : 4'b0011;
            F3_W:    strobe = 4'b1111;
            default: strobe = 4'b0000;
        endcase
        return strobe;
    endfunction

    // Replicate the store data across every lane it could land in, so the
    // strobe alone decides which bytes memory actually writes.
    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] data);
        logic [31:0] lanes;
        lanes = data;
        case (funct3)
            F3_B:    lanes = {4{data[7:0]}};
            F3_H:    lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
// Combinational load formatter: picks the addressed byte or halfword out of
// the bus read word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata     in  32  word returned by data memory
//   addr_lo   in   2  byte offset of the load within the word
//   funct3    in   3  load size/sign (B, H, W, BU, HU)
//   load_data out 32  formatted value for the register file
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = 16'h0000;
        load_data = rdata;

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage load/store unit of the 5-stage RV32I pipeline. Converts the
// EX/MEM access into one word-aligned request on a ready/request data bus,
// formats load results for MEM/WB, and holds the front of the pipeline while
// the access is outstanding.
// Ports:
//   clk, rst        pipeline clock, synchronous active-high reset
//   mem_read_in     load in MEM
//   mem_write_in    store in MEM
//   funct3_in       access size/sign
//   alu_result_in   effective byte address
//   store_data_in   rs2 store value
//   dmem_req        registered bus request
//   dmem_we         1 = write
//   dmem_addr       word address (bits [1:0] always 0)
//   dmem_wstrb      byte-lane write enables
//   dmem_wdata      lane-replicated store data
//   dmem_ready      memory accepts/completes the request this cycle
//   dmem_rdata      read word, valid with dmem_ready
//   mem_data_out    registered formatted load result
//   mem_stall_out   freezes PC, IF/ID, ID/EX and EX/MEM
//   mem_bubble_out  suppresses the MEM/WB register write
//   mem_fault_out   one-cycle flag for a misaligned or illegal access
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_data_out,
    output logic        mem_stall_out,
    output logic        mem_bubble_out,
    output logic        mem_fault_out
);

    mem_state_t  state;
    mem_state_t  next_state;

    logic        access;
    logic        bad_funct3;
    logic        store_unsigned;
    logic        misaligned;
    logic        access_bad;
    logic        illegal_access;
    logic        valid_access;
    logic        stall;

    // Offset and size of the outstanding load, kept so formatting does not
    // depend on EX/MEM staying frozen.
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic [31:0] load_data;

    // Access classification. Only evaluated in IDLE: in REQ/DONE the same
    // already-accepted instruction is still sitting in EX/MEM.
    always_comb begin
        access         = mem_read_in | mem_write_in;
        bad_funct3     = (funct3_in == 3'b011) || (funct3_in == 3'b110) ||
                         (funct3_in == 3'b111);
        store_unsigned = mem_write_in && ((funct3_in == F3_BU) || (funct3_in == F3_HU));
        misaligned     = ((funct3_in == F3_W) && (alu_result_in[1:0] != 2'b00)) ||
                         (((funct3_in == F3_H) || (funct3_in == F3_HU)) && alu_result_in[0]);
        access_bad     = bad_funct3 | store_unsigned | misaligned |
                         (mem_read_in & mem_write_in);
        illegal_access = (state == IDLE) & access & access_bad;
        valid_access   = (state == IDLE) & access & ~access_bad;
    end

    // Next-state and stall logic.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (valid_access) begin
                    next_state = REQ;
                    stall      = 1'b1;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dmem_ready) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign mem_stall_out  = stall;
    assign mem_bubble_out = stall | illegal_access;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    mem_load_align u_load_align (
        .rdata     (dmem_rdata),
        .addr_lo   (addr_lo_q),
        .funct3    (funct3_q),
        .load_data (load_data)
    );

    // Bus fields are loaded once on acceptance and held until the next
    // accepted access; the request drops after the ready cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'h0;
            dmem_wstrb    <= 4'b0000;
            dmem_wdata    <= 32'h0;
            mem_data_out  <= 32'h0;
            mem_fault_out <= 1'b0;
            addr_lo_q     <= 2'b00;
            funct3_q      <= 3'b000;
        end else begin
            mem_fault_out <= illegal_access;
            if (valid_access) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_write_in;
                dmem_addr  <= {alu_result_in[31:2], 2'b00};
                dmem_wstrb <= mem_write_in ? store_strobe(funct3_in, alu_result_in[1:0]) : 4'b0000;
                dmem_wdata <= mem_write_in ? store_lanes(funct3_in, store_data_in) : 32'h0;
                addr_lo_q  <= alu_result_in[1:0];
                funct3_q   <= funct3_in;
            end else if ((state == REQ) && dmem_ready) begin
                dmem_req <= 1'b0;
                if (!dmem_we) begin
                    mem_data_out <= load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed bench for mem_access_unit: a small memory responder that inserts a
// chosen number of wait states, and hand-computed expectations for bus
// fields, stall length, load formatting and fault behaviour.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] mem_data_out;
    logic        mem_stall_out;
    logic        mem_bubble_out;
    logic        mem_fault_out;

    int checks;
    int failures;

    // Bus fields seen on the first request cycle of the last access.
    logic [31:0] capAddr;
    logic        capWe;
    logic [3:0]  capStrb;
    logic [31:0] capWdata;
    logic        capStable;
    int          stallCycles;

    mem_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .funct3_in      (funct3_in),
        .alu_result_in  (alu_result_in),
        .store_data_in  (store_data_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .mem_data_out   (mem_data_out),
        .mem_stall_out  (mem_stall_out),
        .mem_bubble_out (mem_bubble_out),
        .mem_fault_out  (mem_fault_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata);
        mem_read_in   = rd;
        mem_write_in  = wr;
        funct3_in     = f3;
        alu_result_in = addr;
        store_data_in = sdata;
    endtask

    // Presents one access at the start of an IDLE cycle and plays memory with
    // 'waitCycles' not-ready cycles. Returns positioned 1ns into DONE.
    task automatic runAccess(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int waitCycles);
        int  waitLeft;
        bit  seenReq;
        bit  done;
        waitLeft    = waitCycles;
        seenReq     = 1'b0;
        done        = 1'b0;
        stallCycles = 0;
        capStable   = 1'b1;
        @(posedge clk); #1;
        applyStimulus(rd, wr, f3, addr, sdata);
        for (int c = 0; c < 40 && !done; c++) begin
            if (dmem_req) begin
                if (!seenReq) begin
                    capAddr  = dmem_addr;
                    capWe    = dmem_we;
                    capStrb  = dmem_wstrb;
                    capWdata = dmem_wdata;
                end else if (dmem_addr !== capAddr || dmem_we !== capWe ||
                             dmem_wstrb !== capStrb || dmem_wdata !== capWdata) begin
                    capStable = 1'b0;
                end
                seenReq = 1'b1;
                if (waitLeft > 0) begin
                    dmem_ready = 1'b0;
                    waitLeft--;
                end else begin
                    dmem_ready = 1'b1;
                    dmem_rdata = rdata;
                end
            end else begin
                dmem_ready = 1'b0;
                if (seenReq) done = 1'b1;
            end
            if (!done) begin
                @(negedge clk);
                if (mem_stall_out) stallCycles++;
                @(posedge clk); #1;
            end
        end
        if (!done) checkOutput("access_timeout", 32'h0, 32'h1);
    endtask

    task automatic checkFault(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr);
        @(posedge clk); #1;
        applyStimulus(rd, wr, f3, addr, 32'h0);
        @(negedge clk);
        checkOutput({tag, "_bubble"}, 32'(mem_bubble_out), 32'h1);
        checkOutput({tag, "_stall"},  32'(mem_stall_out),  32'h0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checkOutput({tag, "_fault"},  32'(mem_fault_out),  32'h1);
        checkOutput({tag, "_req"},    32'(dmem_req),       32'h0);
        @(posedge clk); #1;
        checkOutput({tag, "_fault_clr"}, 32'(mem_fault_out), 32'h0);
        checkOutput({tag, "_req_idle"},  32'(dmem_req),      32'h0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_req",   32'(dmem_req),      32'h0);
        checkOutput("rst_we",    32'(dmem_we),       32'h0);
        checkOutput("rst_addr",  dmem_addr,          32'h0);
        checkOutput("rst_wstrb", 32'(dmem_wstrb),    32'h0);
        checkOutput("rst_wdata", dmem_wdata,         32'h0);
        checkOutput("rst_data",  mem_data_out,       32'h0);
        checkOutput("rst_fault", 32'(mem_fault_out), 32'h0);
        checkOutput("rst_stall", 32'(mem_stall_out), 32'h0);

        // LW, zero wait states
        runAccess(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        checkOutput("lw_addr",   capAddr,             32'h100);
        checkOutput("lw_we",     32'(capWe),          32'h0);
        checkOutput("lw_wstrb",  32'(capStrb),        32'h0);
        checkOutput("lw_stalls", 32'(stallCycles),    32'd2);
        checkOutput("lw_data",   mem_data_out,        32'hDEADBEEF);
        checkOutput("lw_done_stall",  32'(mem_stall_out),  32'h0);
        checkOutput("lw_done_bubble", 32'(mem_bubble_out), 32'h0);

        // Byte/half load formatting
        runAccess(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF0000, 0);
        checkOutput("lb_addr", capAddr,      32'h200);
        checkOutput("lb_data", mem_data_out, 32'hFFFFFF80);
        runAccess(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF0000, 0);
        checkOutput("lbu_data", mem_data_out, 32'h00000080);
        runAccess(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80FF0000, 0);
        checkOutput("lh_data", mem_data_out, 32'hFFFF80FF);
        runAccess(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h80FF0000, 0);
        checkOutput("lhu_data", mem_data_out, 32'h000080FF);
        runAccess(1'b1, 1'b0, 3'b000, 32'h200, 32'h0, 32'h80FF007F, 0);
        checkOutput("lb0_data", mem_data_out, 32'h0000007F);

        // Stores
        runAccess(1'b0, 1'b1, 3'b000, 32'h301, 32'h123456AB, 32'h0, 0);
        checkOutput("sb_addr",  capAddr,        32'h300);
        checkOutput("sb_we",    32'(capWe),     32'h1);
        checkOutput("sb_wstrb", 32'(capStrb),   32'h2);
        checkOutput("sb_wdata", capWdata,       32'hABABABAB);
        checkOutput("sb_data_hold", mem_data_out, 32'h0000007F);
        runAccess(1'b0, 1'b1, 3'b001, 32'h302, 32'h123456AB, 32'h0, 1);
        checkOutput("sh_wstrb", 32'(capStrb),   32'hC);
        checkOutput("sh_wdata", capWdata,       32'h56AB56AB);
        checkOutput("sh_stalls", 32'(stallCycles), 32'd3);
        runAccess(1'b0, 1'b1, 3'b010, 32'h304, 32'h123456AB, 32'h0, 0);
        checkOutput("sw_addr",  capAddr,        32'h304);
        checkOutput("sw_wstrb", 32'(capStrb),   32'hF);
        checkOutput("sw_wdata", capWdata,       32'h123456AB);
        checkOutput("sw_data_hold", mem_data_out, 32'h0000007F);

        // LW with four wait states
        runAccess(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 4);
        checkOutput("lww_addr",   capAddr,            32'h104);
        checkOutput("lww_stable", 32'(capStable),     32'h1);
        checkOutput("lww_stalls", 32'(stallCycles),   32'd6);
        checkOutput("lww_data",   mem_data_out,       32'hCAFEF00D);

        // Illegal accesses
        checkFault("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h102);
        checkFault("rd_wr_both",  1'b1, 1'b1, 3'b010, 32'h100);
        checkFault("sh_misalign", 1'b0, 1'b1, 3'b001, 32'h301);
        checkFault("sbu_store",   1'b0, 1'b1, 3'b100, 32'h300);
        checkFault("f3_011",      1'b1, 1'b0, 3'b011, 32'h100);
        checkOutput("fault_data_hold", mem_data_out, 32'hCAFEF00D);

        // Reset while a request is outstanding
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h108, 32'h0);
        dmem_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstreq_pre_req", 32'(dmem_req), 32'h1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rstreq_req",   32'(dmem_req),      32'h0);
        checkOutput("rstreq_data",  mem_data_out,       32'h0);
        checkOutput("rstreq_stall", 32'(mem_stall_out), 32'h0);
        runAccess(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h01234567, 0);
        checkOutput("post_rst_stalls", 32'(stallCycles), 32'd2);
        checkOutput("post_rst_data",   mem_data_out,     32'h01234567);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
